fifo_flex: RTL and testbench

Parametrised single-clock FIFO that succeeds the basic memory-interface FIFO. It adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between the memory interface and the compute-side consumers wherever rate decoupling or lookahead reads are needed.

---
 rtl/fifo_flex_pkg.sv | 24 ++
 rtl/fifo_flex_ram.sv | 37 +++
 rtl/fifo_flex.sv | 158 +++++++++++++++
 tb/tb_fifo_flex.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// ============================================================================
// Module      : fifo_flex_pkg
// Description : Shared constants and helpers for the fifo_flex FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_flex_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_flex_ram.sv
// ============================================================================
// Module      : fifo_flex_ram
// Description : Simple dual-port array, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flex_ram
    import fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    // Contents are deliberately left unreset so the array maps onto LUT RAM.
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_flex.sv
// ============================================================================
// Module      : fifo_flex
// Description : Single-clock FIFO with optional FWFT read, programmable
//               almost flags, synchronous flush and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 4,
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter  int FWFT       = 0,
    parameter  int AF_THRESH  = RAM_DEPTH - 2,
    parameter  int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    generate
        if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_fwft
            $error("fifo_flex: FWFT must be 0 or 1");
        end
        if (AF_THRESH > RAM_DEPTH) begin : g_bad_af
            $error("fifo_flex: AF_THRESH exceeds RAM_DEPTH");
        end
        if (AE_THRESH > RAM_DEPTH) begin : g_bad_ae
            $error("fifo_flex: AE_THRESH exceeds RAM_DEPTH");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AF    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] c_AE    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    // Accepts are masked by flush/reset so neither memory nor pointers move then.
    assign w_push_ok = push && !w_full && !flush && !reset;
    assign w_pop_ok  = pop && !w_empty && !flush && !reset;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error event outranks clear_err in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && w_full && !flush) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
            if (pop && w_empty && !flush) begin
                r_underflow <= 1'b1;
            end else if (clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_flex_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign data_out = w_rdata;
            assign valid    = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data_out <= '0;
                    r_valid    <= 1'b0;
                end else if (flush) begin
                    r_valid    <= 1'b0;
                end else begin
                    r_valid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_data_out <= w_rdata;
                    end
                end
            end

            assign data_out = r_data_out;
            assign valid    = r_valid;
        end
    endgenerate

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= c_AE);
    assign almost_full  = (r_count >= c_AF);
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_flex.sv
// ============================================================================
// Module      : tb_fifo_flex
// Description : Self-checking bench driving a standard and an FWFT instance
//               in lockstep against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_flex;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic          clear_err;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_valid, f_valid;
    logic          s_empty, f_empty, s_full, f_full;
    logic          s_ae, f_ae, s_af, f_af;
    logic [AW:0]   s_cnt, f_cnt;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: queue of stored words plus the standard-mode read register.
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_dout;
    logic          m_valid;

    always #5 clk = ~clk;

    fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
        .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop),
        .data_in(data_in), .clear_err(clear_err), .data_out(s_dout),
        .valid(s_valid), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .fifo_count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush), .push(push), .pop(pop),
        .data_in(data_in), .clear_err(clear_err), .data_out(f_dout),
        .valid(f_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .fifo_count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic f, input logic pu,
                              input logic po, input logic ce, input logic [DW-1:0] d);
        int n;
        n = q.size();
        if (r) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_valid = 1'b0;
        end else if (f) begin
            q.delete();
            m_valid = 1'b0;
            if (ce) begin
                m_ovf = 1'b0; m_unf = 1'b0;
            end
        end else begin
            if (pu && n == DEPTH) m_ovf = 1'b1;
            else if (ce)          m_ovf = 1'b0;
            if (po && n == 0)     m_unf = 1'b1;
            else if (ce)          m_unf = 1'b0;
            m_valid = po && (n != 0);
            if (po && n != 0) m_dout = q.pop_front();
            if (pu && n != DEPTH) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std_count",  32'(s_cnt),  32'(n));
        chk("fwft_count", 32'(f_cnt),  32'(n));
        chk("std_empty",  32'(s_empty), 32'(n == 0));
        chk("fwft_empty", 32'(f_empty), 32'(n == 0));
        chk("std_full",   32'(s_full), 32'(n == DEPTH));
        chk("fwft_full",  32'(f_full), 32'(n == DEPTH));
        chk("std_ae",     32'(s_ae),   32'(n <= AE));
        chk("fwft_ae",    32'(f_ae),   32'(n <= AE));
        chk("std_af",     32'(s_af),   32'(n >= AF));
        chk("fwft_af",    32'(f_af),   32'(n >= AF));
        chk("std_ovf",    32'(s_ovf),  32'(m_ovf));
        chk("fwft_ovf",   32'(f_ovf),  32'(m_ovf));
        chk("std_unf",    32'(s_unf),  32'(m_unf));
        chk("fwft_unf",   32'(f_unf),  32'(m_unf));
        chk("std_valid",  32'(s_valid), 32'(m_valid));
        chk("std_dout",   32'(s_dout), 32'(m_dout));
        chk("fwft_valid", 32'(f_valid), 32'(n != 0));
        if (n != 0) chk("fwft_dout", 32'(f_dout), 32'(q[0]));
    endtask

    // One clock: drive inputs, take the edge, advance the model, check 1 time unit later.
    task automatic step(input logic r, input logic f, input logic pu, input logic po,
                        input logic ce, input logic [DW-1:0] d);
        reset = r; flush = f; push = pu; pop = po; clear_err = ce; data_in = d;
        @(posedge clk);
        model_edge(r, f, pu, po, ce, d);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0;
        clear_err = 1'b0; data_in = '0;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_valid = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);

        // Fill, overflow, drain, underflow
        step(0, 0, 1, 0, 0, 8'h11);
        step(0, 0, 1, 0, 0, 8'h22);
        step(0, 0, 1, 0, 0, 8'h33);
        step(0, 0, 1, 0, 0, 8'h44);
        step(0, 0, 1, 0, 0, 8'h55);
        step(0, 0, 1, 1, 0, 8'h66);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);

        // clear_err racing a fresh overflow
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 8'(8'h80 + i));
        step(0, 0, 1, 0, 1, 8'h99);
        step(0, 0, 0, 0, 1, 8'h00);

        // Flush at count 3 with push/pop in the same cycle, underflow flag held
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 1, 1, 1, 0, 8'hEE);
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);

        // Push into empty, then push+pop at occupancy 1
        step(0, 0, 1, 0, 1, 8'hA5);
        step(0, 0, 1, 1, 0, 8'hB6);
        step(0, 0, 0, 1, 0, 8'h00);

        // Pointer wrap with interleaved push/pop
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0, 8'(8'h20 + i));
            step(0, 0, 0, 1, 0, 8'h00);
        end

        // Reset mid-stream, then a clean round trip
        step(0, 0, 1, 0, 0, 8'h01);
        step(0, 0, 1, 0, 0, 8'h02);
        step(0, 0, 1, 0, 0, 8'h03);
        step(0, 0, 1, 0, 0, 8'h04);
        step(0, 0, 1, 0, 0, 8'h05);
        step(1, 0, 1, 1, 0, 8'h06);
        step(0, 0, 1, 0, 0, 8'h7E);
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);

        // Randomised traffic with a drifting push/pop bias
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) < 2 + (bias == 0 ? 1 : 0) - (bias == 2 ? 1 : 0)),
                 ($urandom_range(0, 3) < 2 + (bias == 2 ? 1 : 0) - (bias == 0 ? 1 : 0)),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
